// File: rtl/zilla_hz_pkg.sv
// Shared constants for the hazard/stall controller: stall-cause bit positions,
// multi-cycle unit indices and the tail counter width.
package zilla_hz_pkg;

    localparam int CAUSE_LD   = 0;
    localparam int CAUSE_MC   = 1;
    localparam int CAUSE_MEM  = 2;
    localparam int NUM_CAUSES = 3;

    localparam int MC_MUL = 0;
    localparam int MC_DIV = 1;
    localparam int MC_REM = 2;

    localparam int TAIL_CNT_W = 3;

    typedef logic [TAIL_CNT_W-1:0] tail_cnt_t;

endpackage

// File: rtl/zilla_mc_tail_cnt.sv
// Per-unit stall hold for a multi-cycle execution unit: stalls while the unit is
// valid/busy and for MC_TAIL further cycles after it goes quiet.
module zilla_mc_tail_cnt
    import zilla_hz_pkg::*;
#(
    parameter int MC_TAIL = 2
) (
    input  logic ld_hz_ctrl_clk,
    input  logic ld_hz_ctrl_rst,
    input  logic wdt_reset_i,
    input  logic mc_valid_i,
    input  logic mc_busy_i,
    output logic mc_hz
);

    tail_cnt_t tail_cnt;
    logic      active;

    assign active = mc_valid_i | mc_busy_i;

    // Activity reloads rather than adds, so back-to-back results never stretch the tail.
    always_ff @(posedge ld_hz_ctrl_clk or negedge ld_hz_ctrl_rst) begin
        if (!ld_hz_ctrl_rst) begin
            tail_cnt <= '0;
        end else if (wdt_reset_i) begin
            tail_cnt <= '0;
        end else if (active) begin
            tail_cnt <= TAIL_CNT_W'(MC_TAIL);
        end else if (tail_cnt != '0) begin
            tail_cnt <= tail_cnt - TAIL_CNT_W'(1);
        end
    end

    assign mc_hz = active | (tail_cnt != '0);

endmodule

// File: rtl/zilla_hazard_stall_ctrl.sv
// Load-use / multi-cycle / memory back-pressure stall controller with a
// pending-load scoreboard, registered cause flags and a saturating stall counter.
module zilla_hazard_stall_ctrl
    import zilla_hz_pkg::*;
#(
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int LD_USE_LAT     = 1,
    parameter int NUM_MC_UNITS   = 3,
    parameter int MC_TAIL        = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      ld_hz_ctrl_clk,
    input  logic                      ld_hz_ctrl_rst,
    input  logic                      wdt_reset_i,
    input  logic                      id_ex_mem_rd_en,
    input  logic [GPR_ADDR_WIDTH-1:0] id_ex_rd,
    input  logic [GPR_ADDR_WIDTH-1:0] if_id_rs1,
    input  logic [GPR_ADDR_WIDTH-1:0] if_id_rs2,
    input  logic [NUM_MC_UNITS-1:0]   mc_valid_i,
    input  logic [NUM_MC_UNITS-1:0]   mc_busy_i,
    input  logic                      mem_stall_i,
    output logic                      stall_en,
    output logic                      stall_pipeline,
    output logic [NUM_CAUSES-1:0]     stall_cause,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    input  logic                      clr_cnt_i
);

    logic                    ld0_vld;
    logic                    ld0_hz;
    logic                    sb_hz;
    logic                    load_use_hz;
    logic [NUM_MC_UNITS-1:0] mc_hz;
    logic                    mc_hz_any;
    logic [NUM_CAUSES-1:0]   cause_nxt;

    // x0 loads are never recorded, so rs==0 can never match.
    assign ld0_vld = id_ex_mem_rd_en && (id_ex_rd != '0);
    assign ld0_hz  = ld0_vld && ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    generate
        if (LD_USE_LAT > 1) begin : g_sb
            localparam int DEPTH = LD_USE_LAT - 1;

            logic [DEPTH-1:0]          sb_vld;
            logic [GPR_ADDR_WIDTH-1:0] sb_rd [DEPTH];

            // The load keeps moving down the pipe even while ID is held.
            always_ff @(posedge ld_hz_ctrl_clk or negedge ld_hz_ctrl_rst) begin
                if (!ld_hz_ctrl_rst) begin
                    sb_vld <= '0;
                    for (int k = 0; k < DEPTH; k++) sb_rd[k] <= '0;
                end else if (wdt_reset_i) begin
                    sb_vld <= '0;
                end else begin
                    sb_vld[0] <= ld0_vld;
                    sb_rd[0]  <= id_ex_rd;
                    for (int k = 1; k < DEPTH; k++) begin
                        sb_vld[k] <= sb_vld[k-1];
                        sb_rd[k]  <= sb_rd[k-1];
                    end
                end
            end

            always_comb begin
                sb_hz = 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (sb_vld[k] && ((sb_rd[k] == if_id_rs1) || (sb_rd[k] == if_id_rs2))) begin
                        sb_hz = 1'b1;
                    end
                end
            end
        end else begin : g_no_sb
            assign sb_hz = 1'b0;
        end
    endgenerate

    assign load_use_hz = ld0_hz | sb_hz;

    generate
        for (genvar i = 0; i < NUM_MC_UNITS; i++) begin : g_mc
            zilla_mc_tail_cnt #(
                .MC_TAIL (MC_TAIL)
            ) u_tail (
                .ld_hz_ctrl_clk (ld_hz_ctrl_clk),
                .ld_hz_ctrl_rst (ld_hz_ctrl_rst),
                .wdt_reset_i    (wdt_reset_i),
                .mc_valid_i     (mc_valid_i[i]),
                .mc_busy_i      (mc_busy_i[i]),
                .mc_hz          (mc_hz[i])
            );
        end
    endgenerate

    assign mc_hz_any = |mc_hz;
    assign stall_en  = !wdt_reset_i & (mem_stall_i | mc_hz_any | load_use_hz);

    always_comb begin
        cause_nxt            = '0;
        cause_nxt[CAUSE_LD]  = load_use_hz;
        cause_nxt[CAUSE_MC]  = mc_hz_any;
        cause_nxt[CAUSE_MEM] = mem_stall_i;
    end

    always_ff @(posedge ld_hz_ctrl_clk or negedge ld_hz_ctrl_rst) begin
        if (!ld_hz_ctrl_rst) begin
            stall_pipeline <= 1'b0;
            stall_cause    <= '0;
            stall_cnt      <= '0;
        end else if (wdt_reset_i) begin
            stall_pipeline <= 1'b0;
            stall_cause    <= '0;
            stall_cnt      <= '0;
        end else begin
            stall_pipeline <= stall_en;
            stall_cause    <= cause_nxt;
            if (clr_cnt_i) begin
                stall_cnt <= '0;
            end else if (stall_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_zilla_hazard_stall_ctrl.sv
// Directed bench for zilla_hazard_stall_ctrl: load-use over a 3-deep scoreboard,
// multi-cycle tails, cause flags, counter saturation/clear, watchdog and async reset.
module tb_zilla_hazard_stall_ctrl;
    import zilla_hz_pkg::*;

    localparam int AW   = 5;
    localparam int LAT  = 3;
    localparam int NMC  = 3;
    localparam int TAIL = 2;
    localparam int CW   = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           wdt;
    logic           rd_en;
    logic [AW-1:0]  rd, rs1, rs2;
    logic [NMC-1:0] mc_valid, mc_busy;
    logic           mem_stall;
    logic           clr;
    logic           stall_en;
    logic           stall_pipeline;
    logic [2:0]     stall_cause;
    logic [CW-1:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    zilla_hazard_stall_ctrl #(
        .GPR_ADDR_WIDTH (AW),
        .LD_USE_LAT     (LAT),
        .NUM_MC_UNITS   (NMC),
        .MC_TAIL        (TAIL),
        .CNT_WIDTH      (CW)
    ) dut (
        .ld_hz_ctrl_clk  (clk),
        .ld_hz_ctrl_rst  (rst),
        .wdt_reset_i     (wdt),
        .id_ex_mem_rd_en (rd_en),
        .id_ex_rd        (rd),
        .if_id_rs1       (rs1),
        .if_id_rs2       (rs2),
        .mc_valid_i      (mc_valid),
        .mc_busy_i       (mc_busy),
        .mem_stall_i     (mem_stall),
        .stall_en        (stall_en),
        .stall_pipeline  (stall_pipeline),
        .stall_cause     (stall_cause),
        .stall_cnt       (stall_cnt),
        .clr_cnt_i       (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rd_en     = 1'b0;
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        mc_valid  = '0;
        mc_busy   = '0;
        mem_stall = 1'b0;
        clr       = 1'b0;
        wdt       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b0;
        #12;
        chk("rst_pipe",  stall_pipeline, 0);
        chk("rst_cause", stall_cause, 0);
        chk("rst_cnt",   stall_cnt, 0);
        chk("rst_en",    stall_en, 0);
        rst = 1'b1;
        tick();

        // load-use in the same cycle, and x0 never hazards
        rd_en = 1'b1; rd = 5; rs1 = 5;
        #1 chk("t1_en", stall_en, 1);
        tick();
        chk("t1_pipe",  stall_pipeline, 1);
        chk("t1_cause", stall_cause, 3'b001);
        idle();
        tick(); tick(); tick();
        rd_en = 1'b1; rd = 0; rs1 = 0; rs2 = 0;
        #1 chk("t1_x0_en", stall_en, 0);
        tick();
        chk("t1_x0_pipe", stall_pipeline, 0);

        // pending load rd=7 visible for three cycles with LD_USE_LAT=3
        idle();
        rd_en = 1'b1; rd = 7; rs2 = 7;
        #1 chk("t2_c0", stall_en, 1);
        tick();
        rd_en = 1'b0; rd = 0;
        #1 chk("t2_c1", stall_en, 1);
        chk("t2_c1_cause", stall_cause, 3'b001);
        tick();
        #1 chk("t2_c2", stall_en, 1);
        tick();
        #1 chk("t2_c3", stall_en, 0);

        // busy for 5 cycles, then a 2-cycle tail
        idle();
        tick();
        mc_busy[MC_DIV] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t3_busy", stall_en, 1);
            tick();
        end
        mc_busy = '0;
        #1 chk("t3_tail1", stall_en, 1);
        chk("t3_cause", stall_cause, 3'b010);
        tick();
        #1 chk("t3_tail2", stall_en, 1);
        tick();
        #1 chk("t3_end", stall_en, 0);
        tick();

        // valid pulse inside the tail reloads it
        mc_busy[MC_DIV] = 1'b1;
        tick();
        mc_busy = '0;
        #1 chk("t3_r_tail", stall_en, 1);
        tick();
        mc_valid[MC_DIV] = 1'b1;
        #1 chk("t3_r_pulse", stall_en, 1);
        tick();
        mc_valid = '0;
        #1 chk("t3_r_p1", stall_en, 1);
        tick();
        #1 chk("t3_r_p2", stall_en, 1);
        tick();
        #1 chk("t3_r_end", stall_en, 0);

        // combined causes and counter saturation
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_clr", stall_cnt, 0);
        rd_en = 1'b1; rd = 3; rs1 = 3; mem_stall = 1'b1;
        #1 chk("t4_en", stall_en, 1);
        tick();
        chk("t4_cause", stall_cause, 3'b101);
        chk("t4_cnt1", stall_cnt, 1);
        rd_en = 1'b0; rd = 0; rs1 = 0;
        tick();
        chk("t4_cnt2", stall_cnt, 2);
        chk("t4_cause_mem", stall_cause, 3'b100);
        for (int i = 0; i < 12; i++) tick();
        chk("t4_cnt14", stall_cnt, 14);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_sat", stall_cnt, 15);
        tick();
        chk("t4_sat_hold", stall_cnt, 15);

        // watchdog mid-stall
        idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mc_busy[MC_MUL] = 1'b1; rd_en = 1'b1; rd = 9;
        #1 chk("t5_pre", stall_en, 1);
        tick();
        mc_busy = '0; rd_en = 1'b0; rd = 0; rs1 = 9; wdt = 1'b1;
        #1 chk("t5_wdt_en", stall_en, 0);
        tick();
        wdt = 1'b0;
        #1 chk("t5_after_en", stall_en, 0);
        chk("t5_after_pipe",  stall_pipeline, 0);
        chk("t5_after_cause", stall_cause, 0);
        chk("t5_after_cnt",   stall_cnt, 0);
        mem_stall = 1'b1;
        #1 chk("t5_fresh_en", stall_en, 1);
        tick();
        chk("t5_fresh_cnt", stall_cnt, 1);

        // async reset mid-operation
        mc_busy[MC_REM] = 1'b1;
        tick();
        chk("t6_pre_cnt", stall_cnt, 2);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_pipe",  stall_pipeline, 0);
        chk("t6_rst_cause", stall_cause, 0);
        chk("t6_rst_cnt",   stall_cnt, 0);
        chk("t6_rst_en",    stall_en, 1);
        #5 rst = 1'b1;
        mc_busy = '0;
        clr = 1'b1;
        tick();
        chk("t6_clr_cnt", stall_cnt, 0);
        chk("t6_pipe", stall_pipeline, 1);
        clr = 1'b0;
        tick();
        chk("t6_cnt1", stall_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
